// File: rtl/avr_cpu_regfile_pkg.sv
// Shared constants for the AVR register file: pointer selects, pointer ops
// and the register indices of the X/Y/Z pointer bytes.
package avr_cpu_regfile_pkg;
    localparam logic [1:0] PTR_NONE = 2'd0;
    localparam logic [1:0] PTR_X    = 2'd1;
    localparam logic [1:0] PTR_Y    = 2'd2;
    localparam logic [1:0] PTR_Z    = 2'd3;

    localparam logic [1:0] PTR_OP_PLAIN   = 2'd0;
    localparam logic [1:0] PTR_OP_POSTINC = 2'd1;
    localparam logic [1:0] PTR_OP_PREDEC  = 2'd2;

    localparam logic [4:0] REG_XL = 5'd26;
    localparam logic [4:0] REG_XH = 5'd27;
    localparam logic [4:0] REG_YL = 5'd28;
    localparam logic [4:0] REG_YH = 5'd29;
    localparam logic [4:0] REG_ZL = 5'd30;
    localparam logic [4:0] REG_ZH = 5'd31;
endpackage

// File: rtl/avr_cpu_regfile_ptr_unit.sv
// Combinational pointer arithmetic: effective address and next pointer value
// for post-increment / pre-decrement addressing.
module avr_cpu_ptr_unit
    import avr_cpu_regfile_pkg::*;
(
    input  logic [15:0] ptr,
    input  logic [1:0]  op,
    output logic [15:0] addr,
    output logic [15:0] next,
    output logic        upd
);
    logic [15:0] dec;

    assign dec  = ptr - 16'd1;
    assign addr = (op == PTR_OP_PREDEC) ? dec : ptr;
    assign next = (op == PTR_OP_POSTINC) ? ptr + 16'd1 : dec;
    // reserved op (3) behaves like plain: no write-back
    assign upd  = (op == PTR_OP_POSTINC) || (op == PTR_OP_PREDEC);
endmodule

// File: rtl/avr_cpu_regfile.sv
// AVR 32 x 8 register file with pair writes, X/Y/Z pointer update and
// optional same-cycle write bypass on the read ports.
module avr_cpu_regfile
    import avr_cpu_regfile_pkg::*;
#(
    parameter int FORWARD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  d_addr,
    input  logic [4:0]  r_addr,
    output logic [7:0]  d_out,
    output logic [7:0]  r_out,
    output logic [15:0] d_pair_out,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        wrw_en,
    input  logic [3:0]  wrw_pair,
    input  logic [15:0] wrw_data,
    input  logic [1:0]  ptr_sel,
    input  logic [1:0]  ptr_op,
    output logic [15:0] ptr_addr,
    output logic [15:0] z_out
);
    logic [31:0][7:0] regs;
    logic [31:0][7:0] wv;
    logic [31:0][7:0] fwd;
    logic [31:0]      we;

    logic [3:0]  ptr_pair;
    logic [15:0] ptr_cur, ptr_eff, ptr_next;
    logic        ptr_upd, ptr_act;

    // X/Y/Z are pairs 13/14/15; pointer reads use registered state only
    assign ptr_pair = 4'd12 + {2'b00, ptr_sel};
    assign ptr_cur  = {regs[{ptr_pair, 1'b1}], regs[{ptr_pair, 1'b0}]};

    avr_cpu_ptr_unit u_ptr (
        .ptr  (ptr_cur),
        .op   (ptr_op),
        .addr (ptr_eff),
        .next (ptr_next),
        .upd  (ptr_upd)
    );

    assign ptr_act  = !rst && (ptr_sel != PTR_NONE) && ptr_upd;
    assign ptr_addr = (rst || ptr_sel == PTR_NONE) ? 16'h0000 : ptr_eff;

    // Per-byte priority: byte write > pair write > pointer update
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            we[i] = 1'b0;
            wv[i] = regs[i];
            if (!rst) begin
                if (wr_en && wr_addr == 5'(i)) begin
                    we[i] = 1'b1;
                    wv[i] = wr_data;
                end else if (wrw_en && wrw_pair == 4'(i >> 1)) begin
                    we[i] = 1'b1;
                    wv[i] = i[0] ? wrw_data[15:8] : wrw_data[7:0];
                end else if (ptr_act && ptr_pair == 4'(i >> 1)) begin
                    we[i] = 1'b1;
                    wv[i] = i[0] ? ptr_next[15:8] : ptr_next[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < 32; i++)
                if (we[i]) regs[i] <= wv[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++)
            fwd[i] = (FORWARD != 0 && we[i]) ? wv[i] : regs[i];
    end

    assign d_out      = fwd[d_addr];
    assign r_out      = fwd[r_addr];
    assign d_pair_out = {fwd[{d_addr[4:1], 1'b1}], fwd[{d_addr[4:1], 1'b0}]};
    assign z_out      = {fwd[REG_ZH], fwd[REG_ZL]};
endmodule

// File: tb/tb_avr_cpu_regfile.sv
// Directed bench for avr_cpu_regfile: one forwarding and one registered-read
// instance driven by the same stimulus.
module tb_avr_cpu_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  d_addr, r_addr, wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en, wrw_en;
    logic [3:0]  wrw_pair;
    logic [15:0] wrw_data;
    logic [1:0]  ptr_sel, ptr_op;

    logic [7:0]  d_out, r_out, d_out0, r_out0;
    logic [15:0] d_pair_out, ptr_addr, z_out;
    logic [15:0] d_pair_out0, ptr_addr0, z_out0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avr_cpu_regfile #(.FORWARD(1)) dut (
        .clk(clk), .rst(rst), .d_addr(d_addr), .r_addr(r_addr),
        .d_out(d_out), .r_out(r_out), .d_pair_out(d_pair_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wrw_en(wrw_en), .wrw_pair(wrw_pair), .wrw_data(wrw_data),
        .ptr_sel(ptr_sel), .ptr_op(ptr_op), .ptr_addr(ptr_addr), .z_out(z_out)
    );

    avr_cpu_regfile #(.FORWARD(0)) dut0 (
        .clk(clk), .rst(rst), .d_addr(d_addr), .r_addr(r_addr),
        .d_out(d_out0), .r_out(r_out0), .d_pair_out(d_pair_out0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wrw_en(wrw_en), .wrw_pair(wrw_pair), .wrw_data(wrw_data),
        .ptr_sel(ptr_sel), .ptr_op(ptr_op), .ptr_addr(ptr_addr0), .z_out(z_out0)
    );

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        wrw_en = 0; wrw_pair = 0; wrw_data = 0;
        ptr_sel = 0; ptr_op = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); d_addr = 5; r_addr = 31;
        ptr_sel = 3; ptr_op = 2;
        #2;
        checks++; if (ptr_addr !== 16'h0000) begin errors++; $display("FAIL rst_ptr_addr got %h exp 0000", ptr_addr); end
        checks++; if (z_out !== 16'h0000) begin errors++; $display("FAIL rst_z got %h exp 0000", z_out); end
        idle();
        tick(); tick();
        rst = 0;
        wr_en = 1; wr_addr = 5; wr_data = 8'hA5;
        tick();
        idle();
        #1;
        checks++; if (d_out0 !== 8'hA5) begin errors++; $display("FAIL r5_written got %h exp a5", d_out0); end
        // mid-cycle async reset, no edge
        #1 rst = 1;
        #1;
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL rst_async_d got %h exp 00", d_out); end
        checks++; if (d_out0 !== 8'h00) begin errors++; $display("FAIL rst_async_d0 got %h exp 00", d_out0); end
        checks++; if (z_out !== 16'h0000) begin errors++; $display("FAIL rst_async_z got %h exp 0000", z_out); end
        // writes while reset is held are ignored and not forwarded
        wr_en = 1; wr_addr = 5; wr_data = 8'h33;
        #1;
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL rst_no_fwd got %h exp 00", d_out); end
        tick();
        idle();
        rst = 0;
        #1;
        checks++; if (d_out0 !== 8'h00) begin errors++; $display("FAIL rst_override got %h exp 00", d_out0); end
    endtask

    task automatic test_byte_fwd();
        wr_en = 1; wr_addr = 3; wr_data = 8'h7E; d_addr = 3; r_addr = 3;
        #2;
        checks++; if (d_out !== 8'h7E) begin errors++; $display("FAIL fwd_d got %h exp 7e", d_out); end
        checks++; if (r_out !== 8'h7E) begin errors++; $display("FAIL fwd_r got %h exp 7e", r_out); end
        checks++; if (d_out0 !== 8'h00) begin errors++; $display("FAIL nofwd_d got %h exp 00", d_out0); end
        checks++; if (r_out0 !== 8'h00) begin errors++; $display("FAIL nofwd_r got %h exp 00", r_out0); end
        tick();
        idle();
        #1;
        checks++; if (d_out0 !== 8'h7E) begin errors++; $display("FAIL nofwd_next_d got %h exp 7e", d_out0); end
        checks++; if (r_out0 !== 8'h7E) begin errors++; $display("FAIL nofwd_next_r got %h exp 7e", r_out0); end
    endtask

    task automatic test_pair();
        wrw_en = 1; wrw_pair = 12; wrw_data = 16'hBEEF; d_addr = 25;
        #2;
        checks++; if (d_pair_out !== 16'hBEEF) begin errors++; $display("FAIL pair_fwd got %h exp beef", d_pair_out); end
        tick();
        idle();
        d_addr = 24;
        #1;
        checks++; if (d_pair_out0 !== 16'hBEEF) begin errors++; $display("FAIL pair_24 got %h exp beef", d_pair_out0); end
        checks++; if (d_out0 !== 8'hEF) begin errors++; $display("FAIL r24 got %h exp ef", d_out0); end
        d_addr = 25;
        #1;
        checks++; if (d_pair_out0 !== 16'hBEEF) begin errors++; $display("FAIL pair_25 got %h exp beef", d_pair_out0); end
        checks++; if (d_out0 !== 8'hBE) begin errors++; $display("FAIL r25 got %h exp be", d_out0); end
    endtask

    task automatic test_ptr_x_wrap();
        wrw_en = 1; wrw_pair = 13; wrw_data = 16'hFFFF;
        tick();
        idle();
        ptr_sel = 1; ptr_op = 1;
        #1;
        checks++; if (ptr_addr !== 16'hFFFF) begin errors++; $display("FAIL x_postinc_addr got %h exp ffff", ptr_addr); end
        checks++; if (ptr_addr0 !== 16'hFFFF) begin errors++; $display("FAIL x_postinc_addr0 got %h exp ffff", ptr_addr0); end
        tick();
        idle();
        d_addr = 27;
        #1;
        checks++; if (d_pair_out0 !== 16'h0000) begin errors++; $display("FAIL x_wrap got %h exp 0000", d_pair_out0); end
        // plain op and reserved op leave the pointer alone
        ptr_sel = 1; ptr_op = 3;
        #1;
        checks++; if (ptr_addr !== 16'h0000) begin errors++; $display("FAIL x_rsvd_addr got %h exp 0000", ptr_addr); end
        tick();
        ptr_op = 1;
        tick(); tick(); tick();
        idle();
        #1;
        checks++; if (d_pair_out0 !== 16'h0003) begin errors++; $display("FAIL x_hold3 got %h exp 0003", d_pair_out0); end
    endtask

    task automatic test_ptr_y_predec();
        ptr_sel = 2; ptr_op = 2;
        #1;
        checks++; if (ptr_addr !== 16'hFFFF) begin errors++; $display("FAIL y_predec1 got %h exp ffff", ptr_addr); end
        tick();
        checks++; if (ptr_addr !== 16'hFFFE) begin errors++; $display("FAIL y_predec2 got %h exp fffe", ptr_addr); end
        tick();
        idle();
        d_addr = 28;
        #1;
        checks++; if (d_pair_out0 !== 16'hFFFE) begin errors++; $display("FAIL y_after got %h exp fffe", d_pair_out0); end
        checks++; if (ptr_addr !== 16'h0000) begin errors++; $display("FAIL sel_none_addr got %h exp 0000", ptr_addr); end
    endtask

    task automatic test_priority();
        wrw_en = 1; wrw_pair = 15; wrw_data = 16'h10FF;
        tick();
        idle();
        ptr_sel = 3; ptr_op = 1; wr_en = 1; wr_addr = 30; wr_data = 8'h55;
        #1;
        checks++; if (z_out !== 16'h1155) begin errors++; $display("FAIL z_fwd got %h exp 1155", z_out); end
        checks++; if (z_out0 !== 16'h10FF) begin errors++; $display("FAIL z_nofwd got %h exp 10ff", z_out0); end
        checks++; if (ptr_addr !== 16'h10FF) begin errors++; $display("FAIL z_addr got %h exp 10ff", ptr_addr); end
        tick();
        idle();
        #1;
        checks++; if (z_out0 !== 16'h1155) begin errors++; $display("FAIL z_after got %h exp 1155", z_out0); end
        // pair write beats pointer update on X; byte beats pair on r4
        ptr_sel = 1; ptr_op = 2; wrw_en = 1; wrw_pair = 13; wrw_data = 16'hABCD;
        tick();
        idle();
        wrw_en = 1; wrw_pair = 2; wrw_data = 16'h1234; wr_en = 1; wr_addr = 4; wr_data = 8'h99;
        tick();
        idle();
        d_addr = 26;
        #1;
        checks++; if (d_pair_out0 !== 16'hABCD) begin errors++; $display("FAIL pair_over_ptr got %h exp abcd", d_pair_out0); end
        d_addr = 4;
        #1;
        checks++; if (d_pair_out0 !== 16'h1299) begin errors++; $display("FAIL byte_over_pair got %h exp 1299", d_pair_out0); end
        // untouched earlier data still intact
        r_addr = 3;
        #1;
        checks++; if (r_out0 !== 8'h7E) begin errors++; $display("FAIL r3_kept got %h exp 7e", r_out0); end
    endtask

    initial begin
        test_reset();
        test_byte_fwd();
        test_pair();
        test_ptr_x_wrap();
        test_ptr_y_predec();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
